// File: rtl/uwasic_onboarding_emily_au_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uwasic_onboarding_emily_au_pkg
//  Description : Shared constants and types for the SPI-controlled
//                16-channel PWM peripheral (register map, frame length,
//                default PWM prescaler).
//  Revision    : 1.0 - initial release
// ============================================================================
package uwasic_onboarding_emily_au_pkg;

    // Control register addresses
    localparam logic [6:0] ADDR_EN_OUT_LO = 7'd0;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'd1;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'd2;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'd3;
    localparam logic [6:0] ADDR_DUTY      = 7'd4;
    localparam logic [6:0] MAX_ADDR       = 7'd4;

    // Bits per SPI frame: R/W, 7-bit address, 8-bit data
    localparam int FRAME_BITS = 16;

    // clk cycles per PWM counter step (10 MHz / (13*256) ~= 3.0 kHz)
    localparam int PRESCALE = 13;

    typedef logic [7:0] reg8_t;

endpackage
`default_nettype wire

// File: rtl/uwasic_onboarding_emily_au_spi_peripheral.sv
`default_nettype none
// ============================================================================
//  Module      : uwasic_onboarding_emily_au_spi_peripheral
//  Description : Write-only SPI mode-0 peripheral. Synchronises SCLK/COPI/nCS
//                into clk, shifts in a 16-bit frame and commits it to one of
//                five control registers on the nCS rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module uwasic_onboarding_emily_au_spi_peripheral
    import uwasic_onboarding_emily_au_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_sclk,
    input  logic        i_copi,
    input  logic        i_ncs,
    output logic [15:0] o_en_out,
    output logic [15:0] o_en_pwm,
    output logic [7:0]  o_duty
);

    logic [1:0]  r_sclk_sync;
    logic [1:0]  r_copi_sync;
    logic [1:0]  r_ncs_sync;
    logic        r_sclk_prev;
    logic        r_ncs_prev;
    logic [15:0] r_shift;
    logic [4:0]  r_bit_cnt;
    reg8_t       r_en_out_lo;
    reg8_t       r_en_out_hi;
    reg8_t       r_en_pwm_lo;
    reg8_t       r_en_pwm_hi;
    reg8_t       r_duty;

    logic        w_sclk_rise;
    logic        w_ncs_fall;
    logic        w_ncs_rise;
    logic        w_frame_full;
    logic        w_commit;
    logic [6:0]  w_addr;

    // Edges are taken between the synchronised value and its previous copy
    assign w_sclk_rise  = r_sclk_sync[1] & ~r_sclk_prev;
    assign w_ncs_fall   = ~r_ncs_sync[1] & r_ncs_prev;
    assign w_ncs_rise   = r_ncs_sync[1] & ~r_ncs_prev;
    assign w_frame_full = (r_bit_cnt == 5'(FRAME_BITS));
    assign w_addr       = r_shift[14:8];
    assign w_commit     = w_ncs_rise & w_frame_full & r_shift[15] & (w_addr <= MAX_ADDR);

    // Two-flop synchronisers plus one history flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= 2'b00;
            r_copi_sync <= 2'b00;
            r_ncs_sync  <= 2'b11;
            r_sclk_prev <= 1'b0;
            r_ncs_prev  <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[0], i_sclk};
            r_copi_sync <= {r_copi_sync[0], i_copi};
            r_ncs_sync  <= {r_ncs_sync[0], i_ncs};
            r_sclk_prev <= r_sclk_sync[1];
            r_ncs_prev  <= r_ncs_sync[1];
        end
    end

    // Frame capture: cleared on nCS fall, shifts MSB-first while selected, saturates at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= 16'h0000;
            r_bit_cnt <= 5'd0;
        end else if (w_ncs_fall) begin
            r_shift   <= 16'h0000;
            r_bit_cnt <= 5'd0;
        end else if (!r_ncs_sync[1] && w_sclk_rise && !w_frame_full) begin
            r_shift   <= {r_shift[14:0], r_copi_sync[1]};
            r_bit_cnt <= r_bit_cnt + 5'd1;
        end
    end

    // Register file: a complete, in-range write frame commits when nCS rises
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_out_lo <= 8'h00;
            r_en_out_hi <= 8'h00;
            r_en_pwm_lo <= 8'h00;
            r_en_pwm_hi <= 8'h00;
            r_duty      <= 8'h00;
        end else if (w_commit) begin
            case (w_addr)
                ADDR_EN_OUT_LO: r_en_out_lo <= r_shift[7:0];
                ADDR_EN_OUT_HI: r_en_out_hi <= r_shift[7:0];
                ADDR_EN_PWM_LO: r_en_pwm_lo <= r_shift[7:0];
                ADDR_EN_PWM_HI: r_en_pwm_hi <= r_shift[7:0];
                ADDR_DUTY:      r_duty      <= r_shift[7:0];
                default:        ;
            endcase
        end
    end

    assign o_en_out = {r_en_out_hi, r_en_out_lo};
    assign o_en_pwm = {r_en_pwm_hi, r_en_pwm_lo};
    assign o_duty   = r_duty;

endmodule
`default_nettype wire

// File: rtl/uwasic_onboarding_emily_au.sv
`default_nettype none
// ============================================================================
//  Module      : uwasic_onboarding_emily_au
//  Description : Top level of the SPI-controlled 16-channel PWM peripheral.
//                Holds the shared prescaler / 8-bit PWM counter and the
//                per-channel output muxing (off / high / PWM).
//  Revision    : 1.0 - initial release
// ============================================================================
module uwasic_onboarding_emily_au
    import uwasic_onboarding_emily_au_pkg::*;
#(
    parameter int PRESCALE = uwasic_onboarding_emily_au_pkg::PRESCALE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    // Prescaler width, kept at least one bit wide for PRESCALE == 1
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0] r_pre;
    logic [7:0]      r_pwm_cnt;

    logic [15:0]     w_en_out;
    logic [15:0]     w_en_pwm;
    logic [7:0]      w_duty;
    logic            w_pre_wrap;
    logic            w_pwm;
    logic [15:0]     w_chan;
    logic            w_unused;

    assign w_unused = &{1'b0, ena, uio_in, ui_in[7:3]};

    uwasic_onboarding_emily_au_spi_peripheral u_spi_peripheral (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_sclk   (ui_in[0]),
        .i_copi   (ui_in[1]),
        .i_ncs    (ui_in[2]),
        .o_en_out (w_en_out),
        .o_en_pwm (w_en_pwm),
        .o_duty   (w_duty)
    );

    assign w_pre_wrap = (r_pre == PS_W'(PRESCALE - 1));

    // Free-running prescaler; the PWM counter steps once per prescaler wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre     <= '0;
            r_pwm_cnt <= 8'h00;
        end else if (w_pre_wrap) begin
            r_pre     <= '0;
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
        end else begin
            r_pre     <= r_pre + PS_W'(1);
        end
    end

    // duty 0xFF is forced fully on; otherwise high while the counter is below duty
    assign w_pwm = (w_duty == 8'hFF) ? 1'b1 : (r_pwm_cnt < w_duty);

    // Per channel: disabled -> 0, enabled -> PWM if selected, else constant 1
    assign w_chan  = w_en_out & (~w_en_pwm | {16{w_pwm}});
    assign uo_out  = w_chan[7:0];
    assign uio_out = w_chan[15:8];
    assign uio_oe  = 8'hFF;

endmodule
`default_nettype wire

// File: tb/tb_uwasic_onboarding_emily_au.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uwasic_onboarding_emily_au
//  Description : Directed self-checking bench for the SPI PWM peripheral.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uwasic_onboarding_emily_au;

    localparam int PERIOD = 13 * 256;   // clk cycles per full PWM period

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       sclk, copi, ncs;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_vec = 0;
    int n_err = 0;

    assign ui_in = {5'b00000, ncs, copi, sclk};

    uwasic_onboarding_emily_au #(.PRESCALE(13)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic spi_bit(input logic b);
        copi = b;
        repeat (10) @(posedge clk);
        sclk = 1'b1;
        repeat (10) @(posedge clk);
        sclk = 1'b0;
    endtask

    // Bits beyond the 16th are driven as 1
    task automatic spi_send(input logic [15:0] w, input int n);
        ncs = 1'b0;
        repeat (10) @(posedge clk);
        for (int i = 0; i < n; i++) spi_bit((i < 16) ? w[15-i] : 1'b1);
        repeat (10) @(posedge clk);
        ncs = 1'b1;
        repeat (20) @(posedge clk);
    endtask

    task automatic spi_write(input logic [6:0] a, input logic [7:0] d);
        spi_send({1'b1, a, d}, 16);
    endtask

    // Over one full PWM period: cycles matching hi_pat, and cycles matching neither pattern
    task automatic measure(input logic [15:0] hi_pat, input logic [15:0] lo_pat,
                           output int hi, output int bad);
        hi  = 0;
        bad = 0;
        repeat (PERIOD) begin
            @(negedge clk);
            if ({uio_out, uo_out} === hi_pat) hi++;
            else if ({uio_out, uo_out} !== lo_pat) bad++;
        end
    endtask

    initial begin
        int hi, bad;
        ena    = 1'b1;
        uio_in = 8'h00;
        sclk   = 1'b0;
        copi   = 1'b0;
        ncs    = 1'b1;
        rst_n  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_outputs", {uio_out, uo_out}, 16'h0000);
        check("rst_oe", {8'h00, uio_oe}, 16'h00FF);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_outputs", {uio_out, uo_out}, 16'h0000);
        check("post_rst_oe", {8'h00, uio_oe}, 16'h00FF);

        // Static enables, no PWM
        spi_write(7'h00, 8'h27);
        @(negedge clk);
        check("en_out_lo", {uio_out, uo_out}, 16'h0027);
        measure(16'h0027, 16'h0027, hi, bad);
        check("en_out_lo_const", 16'(hi), 16'(PERIOD));

        // Back-to-back writes: pwm channels uo[1,2], uio[0,2,7]; const-1 uo[0,5], uio[1,5,6]
        spi_write(7'h01, 8'hE7);
        spi_write(7'h02, 8'h96);
        spi_write(7'h03, 8'h85);
        spi_write(7'h04, 8'h11);
        measure(16'hE727, 16'h6221, hi, bad);
        check("duty11_high", 16'(hi), 16'(17 * 13));
        check("duty11_other", 16'(bad), 16'd0);

        // duty 0x00: PWM channels constant 0
        spi_write(7'h04, 8'h00);
        measure(16'hE727, 16'h6221, hi, bad);
        check("duty00_high", 16'(hi), 16'd0);
        check("duty00_other", 16'(bad), 16'd0);

        // duty 0xFF: PWM channels constant 1
        spi_write(7'h04, 8'hFF);
        measure(16'hE727, 16'h6221, hi, bad);
        check("dutyFF_high", 16'(hi), 16'(PERIOD));

        // duty 0x80 in a 20-bit frame: extra bits ignored, 50 % duty
        spi_send({1'b1, 7'h04, 8'h80}, 20);
        measure(16'hE727, 16'h6221, hi, bad);
        check("duty80_high", 16'(hi), 16'(128 * 13));
        check("duty80_other", 16'(bad), 16'd0);

        // Dropped frames
        spi_write(7'h04, 8'hFF);
        spi_send({1'b0, 7'h00, 8'h00}, 16);     // read to en_out_lo
        @(negedge clk);
        check("read_ignored", {uio_out, uo_out}, 16'hE727);
        spi_send({1'b0, 7'h04, 8'h00}, 16);     // read to duty
        measure(16'hE727, 16'h6221, hi, bad);
        check("read_duty_ignored", 16'(hi), 16'(PERIOD));
        spi_write(7'h05, 8'h00);                // out-of-range address
        spi_write(7'h0C, 8'h00);
        @(negedge clk);
        check("addr_oob_ignored", {uio_out, uo_out}, 16'hE727);
        spi_send({1'b1, 7'h00, 8'h00}, 10);     // short frame
        @(negedge clk);
        check("short_ignored", {uio_out, uo_out}, 16'hE727);

        // Reset in the middle of a frame
        ncs = 1'b0;
        repeat (10) @(posedge clk);
        for (int i = 0; i < 8; i++) spi_bit(i == 0);
        #7 rst_n = 1'b0;
        #1;
        check("midframe_rst_async", {uio_out, uo_out}, 16'h0000);
        repeat (5) @(negedge clk);
        ncs   = 1'b1;
        repeat (20) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("midframe_rst_cleared", {uio_out, uo_out}, 16'h0000);
        spi_write(7'h00, 8'h03);
        @(negedge clk);
        check("after_rst_write", {uio_out, uo_out}, 16'h0003);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
